// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory loader.
// Frame sync byte, FSM state encoding and error codes.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_COUNT   = 2'b01,
        ERR_CHK     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port bundle.
// master = byte source / memory side, slave = the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 7
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/loader_timeout.sv
// Inter-byte idle counter for the loader.
// Pulses expire_o when the idle limit is hit; TIMEOUT_CYC = 0 disables it.
module loader_timeout #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam logic        ENABLED = (TIMEOUT_CYC != 16'd0);
    localparam logic [15:0] LAST    = TIMEOUT_CYC - 16'd1;

    logic [15:0] cnt_q, cnt_d;

    // Next count: clear has priority, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !ENABLED) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign expire_o = ENABLED && en_i && !clr_i && (cnt_q == LAST);

    // Counter register with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed serial-to-instruction-memory loader.
// Parses SYNC/COUNT/DATA/CHK frames and writes 32-bit words.
module imem_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W      = 7,
    parameter int          DEPTH       = 128,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic            clock,
    input  logic            reset_n,
    imem_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code,
    output logic [ADDR_W:0] words_loaded
);
    localparam int CW = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     words_q, words_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    err_e              err_q, err_d;

    logic              accept;
    logic              busy;
    logic              expire;
    logic [31:0]       word_nx;

    assign bus.in_ready = 1'b1;
    assign accept       = bus.in_valid & bus.in_ready;
    assign busy         = state_q inside {ST_COUNT, ST_DATA, ST_CHK};
    assign word_nx      = {word_q[23:0], bus.in_data};

    loader_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clock_i  (clock),
        .reset_ni (reset_n),
        .clr_i    (accept | ~busy),
        .en_i     (busy),
        .expire_o (expire)
    );

    // Frame parser: next state, word assembly, checksum and write strobe.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        words_d = words_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept && bus.in_data == SYNC_BYTE) begin
                    state_d = ST_COUNT;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    err_d   = ERR_NONE;
                    words_d = '0;
                    chk_d   = '0;
                    bidx_d  = '0;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if (bus.in_data == 8'd0 ||
                        32'(bus.in_data) > DEPTH) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_COUNT;
                    end else begin
                        n_d     = CW'(bus.in_data);
                        bidx_d  = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    word_d = word_nx;
                    chk_d  = chk_q ^ bus.in_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = word_nx;
                        words_d = words_q + CW'(1);
                        if (words_q + CW'(1) == n_q) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (bus.in_data == chk_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_CHK;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // expire only fires in a busy state with no byte this cycle
        if (expire) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            err_d   = ERR_TIMEOUT;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            words_q <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            chk_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = busy;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame vector table,
// directed corner sequences and randomized frames vs a frame-level model.
module tb_imem_loader;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic            clock;
    logic            reset_n;
    logic            cpu_hold;
    logic            done;
    logic            error;
    logic [1:0]      err_code;
    logic [ADDR_W:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (16'd16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [31:0] act_mem [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    bit          exp_set [DEPTH];

    // Write monitor: every strobe lands in the shadow memory.
    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            we_cnt++;
            act_mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic gap();
        int g;
        g = $urandom_range(0, 3);
        if (g > 0) idle(g);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
        chk({tag, " err_code"}, 32'(err_code), 32'd0);
        chk({tag, " words"}, 32'(words_loaded), 32'd0);
    endtask

    typedef struct {
        int          len;
        logic [127:0] s;
        logic        done;
        logic        err;
        logic [1:0]  code;
        int          words;
        int          writes;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input int len, input logic [127:0] s,
                                input logic d, input logic e,
                                input logic [1:0] c, input int w,
                                input int wr);
        vec_t v;
        v.len    = len;
        v.s      = s;
        v.done   = d;
        v.err    = e;
        v.code   = c;
        v.words  = w;
        v.writes = wr;
        return v;
    endfunction

    initial begin
        int base;
        int nb;
        string tg;

        vecs[0] = mk(11, 128'({8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                               8'h00, 8'h00, 8'h00, 8'h01, 8'h2C}),
                     1'b1, 1'b0, 2'b00, 2, 2);
        vecs[1] = mk(11, 128'({8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                               8'h00, 8'h00, 8'h00, 8'h01, 8'h00}),
                     1'b0, 1'b1, 2'b10, 2, 2);
        vecs[2] = mk(2, 128'({8'hA5, 8'h00}), 1'b0, 1'b1, 2'b01, 0, 0);
        vecs[3] = mk(2, 128'({8'hA5, 8'h81}), 1'b0, 1'b1, 2'b01, 0, 0);
        vecs[4] = mk(9, 128'({8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01,
                              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}),
                     1'b1, 1'b0, 2'b00, 1, 1);
        vecs[4].len = 10;

        for (int i = 0; i < DEPTH; i++) begin
            act_mem[i] = '0;
            exp_mem[i] = '0;
            exp_set[i] = 1'b0;
        end

        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        idle(2);
        check_reset("reset");
        reset_n = 1'b1;

        // noise in IDLE is ignored
        base = we_cnt;
        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        idle(1);
        chk("noise hold", 32'(cpu_hold), 32'd0);
        chk("noise done", 32'(done), 32'd0);
        chk("noise writes", 32'(we_cnt - base), 32'd0);

        // frame vector table
        for (int v = 0; v < 5; v++) begin
            base = we_cnt;
            for (int i = 0; i < vecs[v].len; i++) begin
                send(vecs[v].s[8*(vecs[v].len-1-i) +: 8]);
            end
            idle(2);
            tg = $sformatf("vec%0d", v);
            chk({tg, " done"}, 32'(done), 32'(vecs[v].done));
            chk({tg, " error"}, 32'(error), 32'(vecs[v].err));
            chk({tg, " err_code"}, 32'(err_code), 32'(vecs[v].code));
            chk({tg, " words"}, 32'(words_loaded), 32'(vecs[v].words));
            chk({tg, " hold"}, 32'(cpu_hold), 32'd0);
            chk({tg, " writes"}, 32'(we_cnt - base), 32'(vecs[v].writes));
            if (v == 0) begin
                chk("vec0 mem0", act_mem[0], 32'h20080005);
                chk("vec0 mem1", act_mem[1], 32'h00000001);
            end
            if (v == 4) begin
                chk("vec4 mem0", act_mem[0], 32'hDEADBEEF);
            end
        end

        // timeout: 16 idle cycles inside DATA
        base = we_cnt;
        send(8'hA5);
        send(8'h01);
        send(8'h12);
        idle(15);
        chk("tmo pre hold", 32'(cpu_hold), 32'd1);
        chk("tmo pre error", 32'(error), 32'd0);
        idle(1);
        chk("tmo error", 32'(error), 32'd1);
        chk("tmo err_code", 32'(err_code), 32'd3);
        chk("tmo hold", 32'(cpu_hold), 32'd0);
        chk("tmo done", 32'(done), 32'd0);
        chk("tmo writes", 32'(we_cnt - base), 32'd0);

        // reset mid-frame after two data bytes
        base = we_cnt;
        send(8'hA5);
        send(8'h02);
        send(8'h20);
        send(8'h08);
        reset_n = 1'b0;
        idle(1);
        check_reset("midrst");
        reset_n = 1'b1;
        send(8'h00);
        send(8'h05);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'h01);
        send(8'h2C);
        idle(2);
        chk("midrst writes", 32'(we_cnt - base), 32'd0);
        chk("midrst hold", 32'(cpu_hold), 32'd0);
        chk("midrst words", 32'(words_loaded), 32'd0);

        // randomized frames against a frame-level model
        for (int f = 0; f < 40; f++) begin
            int          n;
            int          r;
            logic [7:0]  x;
            logic [7:0]  nz;
            logic [31:0] w32;
            logic        good;

            base = we_cnt;
            nb = $urandom_range(0, 2);
            for (int k = 0; k < nb; k++) begin
                nz = 8'($urandom_range(0, 255));
                if (nz == 8'hA5) nz = 8'h5A;
                send(nz);
            end
            gap();
            send(8'hA5);
            chk("rnd hold", 32'(cpu_hold), 32'd1);

            r = $urandom_range(0, 9);
            if (f == 0) n = DEPTH;
            else if (r == 0) n = 0;
            else if (r == 1) n = $urandom_range(DEPTH + 1, 255);
            else n = $urandom_range(1, 6);
            gap();
            send(8'(n));

            if (n == 0 || n > DEPTH) begin
                idle(1);
                chk("rnd cnt error", 32'(error), 32'd1);
                chk("rnd cnt code", 32'(err_code), 32'd1);
                chk("rnd cnt hold", 32'(cpu_hold), 32'd0);
                chk("rnd cnt writes", 32'(we_cnt - base), 32'd0);
            end else begin
                x = '0;
                for (int w = 0; w < n; w++) begin
                    w32 = $urandom;
                    for (int b = 0; b < 4; b++) begin
                        gap();
                        send(w32[8*(3-b) +: 8]);
                        x = x ^ w32[8*(3-b) +: 8];
                    end
                    chk("rnd we", 32'(bus.mem_we), 32'd1);
                    chk("rnd addr", 32'(bus.mem_addr), 32'(w));
                    chk("rnd wdata", bus.mem_wdata, w32);
                    chk("rnd words", 32'(words_loaded), 32'(w + 1));
                    exp_mem[w] = w32;
                    exp_set[w] = 1'b1;
                end
                good = ($urandom_range(0, 3) != 0);
                gap();
                if (good) send(x);
                else send(x ^ 8'($urandom_range(1, 255)));
                idle(1);
                chk("rnd done", 32'(done), 32'(good));
                chk("rnd error", 32'(error), 32'(!good));
                chk("rnd code", 32'(err_code), good ? 32'd0 : 32'd2);
                chk("rnd fwords", 32'(words_loaded), 32'(n));
                chk("rnd fhold", 32'(cpu_hold), 32'd0);
                chk("rnd writes", 32'(we_cnt - base), 32'(n));
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (exp_set[i]) begin
                chk($sformatf("mem[%0d]", i), act_mem[i], exp_mem[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
